// File: rtl/uart_cmd_resp_mstr.sv
// uart_cmd_resp_mstr: UART command master for the DSO host link.
// Sends CMD_BYTES command bytes MSB-byte-first through uart_tx, then collects
// RESP_BYTES response bytes from uart_rx into resp (first byte lands in the MS
// byte). It aborts with a sticky timeout if the gap between response bytes
// exceeds TIMEOUT_CYC clocks.
// Optional build macro UART_CMD_CHKSUM_EN appends a two's-complement checksum
// byte to the command, expects one extra checksum byte in the response, and
// adds the sticky resp_err output.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   RX / TX           UART receive / transmit lines
//   cmd, send_cmd     command word and start request (sampled in IDLE only)
//   busy              high while a transaction is in progress
//   cmd_sent          one-cycle pulse after the last command byte is sent
//   resp, resp_rdy    response word and sticky ready flag
//   clr_resp_rdy      clears resp_rdy
//   timeout           sticky response-timeout flag
//   resp_err          (UART_CMD_CHKSUM_EN only) sticky response checksum error
// BAUD_DIV is the clk-per-bit divisor handed to the UART children.

module uart_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       TX,
    output logic       tx_done
);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    logic [8:0]  shft;
    logic [3:0]  bit_cnt;
    logic [15:0] baud_cnt;
    logic        xmit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shft <= '1; bit_cnt <= '0; baud_cnt <= '0; xmit <= 1'b0; tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (trmt && !xmit) begin
                shft <= {tx_data, 1'b0};
                bit_cnt <= '0; baud_cnt <= '0; xmit <= 1'b1;
            end else if (xmit) begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt <= '0;
                    shft <= {1'b1, shft[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        xmit <= 1'b0; tx_done <= 1'b1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + 16'd1;
                end
            end
        end
    end

    assign TX = shft[0];
endmodule

module uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2);
    logic        rx_s1, rx_s2, rcv;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;

    // Sample 0 is the start bit, samples 1..8 are data, sample 9 is the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1; rx_s2 <= 1'b1; rcv <= 1'b0;
            baud_cnt <= '0; bit_cnt <= '0; rx_data <= '0; rdy <= 1'b0;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            if (clr_rdy) rdy <= 1'b0;
            if (!rcv) begin
                if (!rx_s2) begin
                    rcv <= 1'b1; baud_cnt <= BAUD_HALF; bit_cnt <= '0;
                end
            end else if (baud_cnt == BAUD_LAST) begin
                baud_cnt <= '0;
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt != 4'd0 && bit_cnt != 4'd9) rx_data <= {rx_s2, rx_data[7:1]};
                if (bit_cnt == 4'd9) begin
                    rcv <= 1'b0; rdy <= 1'b1;
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end
endmodule

module uart_cmd_resp_mstr #(
    parameter int CMD_BYTES   = 3,
    parameter int RESP_BYTES  = 1,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int BAUD_DIV    = 2604
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            RX,
    output logic                                            TX,
    input  logic [8*CMD_BYTES-1:0]                          cmd,
    input  logic                                            send_cmd,
    output logic                                            busy,
    output logic                                            cmd_sent,
    output logic [(RESP_BYTES == 0 ? 8 : 8*RESP_BYTES)-1:0] resp,
    output logic                                            resp_rdy,
    input  logic                                            clr_resp_rdy,
    output logic                                            timeout
`ifdef UART_CMD_CHKSUM_EN
    ,
    output logic                                            resp_err
`endif
);
    localparam int RESP_W = (RESP_BYTES == 0) ? 8 : 8 * RESP_BYTES;
`ifdef UART_CMD_CHKSUM_EN
    localparam int CMD_TOT  = CMD_BYTES + 1;
    localparam int RESP_TOT = RESP_BYTES + 1;
`else
    localparam int CMD_TOT  = CMD_BYTES;
    localparam int RESP_TOT = RESP_BYTES;
`endif
    localparam int             TMO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
    localparam logic [3:0]     CMD_LAST   = 4'(CMD_TOT - 1);
    localparam logic [3:0]     RESP_LAST  = 4'(RESP_TOT - 1);
    localparam logic [3:0]     RESP_STORE = 4'(RESP_BYTES);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_TX, RECV} state_t;

    state_t                 state, state_nxt;
    logic [8*CMD_TOT-1:0]   sh, sh_nxt, load_word;
    logic [3:0]             cnt, cnt_nxt;
    logic [TMO_W-1:0]       tmo, tmo_nxt;
    logic [RESP_W-1:0]      resp_nxt;
    logic                   resp_rdy_nxt, timeout_nxt, cmd_sent_nxt;
    logic                   rst_n_r, trmt, tx_done, clr_rdy, rx_rdy;
    logic [7:0]             tx_data, rx_data;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]             csum, rsum, rsum_nxt;
    logic                   resp_err_nxt;
`endif

    uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk(clk), .rst_n(rst_n_r), .tx_data(tx_data), .trmt(trmt), .TX(TX), .tx_done(tx_done)
    );
    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk(clk), .rst_n(rst_n_r), .RX(RX), .clr_rdy(clr_rdy), .rx_data(rx_data), .rdy(rx_rdy)
    );

    always_comb begin
`ifdef UART_CMD_CHKSUM_EN
        csum = '0;
        for (int unsigned i = 0; i < CMD_BYTES; i++) csum = csum + cmd[8*i +: 8];
        load_word = {cmd, 8'(8'd0 - csum)};
`else
        load_word = cmd;
`endif
    end

    always_comb begin
        state_nxt    = state;
        sh_nxt       = sh;
        cnt_nxt      = cnt;
        tmo_nxt      = tmo;
        resp_nxt     = resp;
        resp_rdy_nxt = resp_rdy;
        timeout_nxt  = timeout;
        cmd_sent_nxt = 1'b0;
        trmt         = 1'b0;
        clr_rdy      = 1'b0;
        tx_data      = sh[8*CMD_TOT-1 -: 8];
`ifdef UART_CMD_CHKSUM_EN
        rsum_nxt     = rsum;
        resp_err_nxt = resp_err;
`endif
        if (clr_resp_rdy) resp_rdy_nxt = 1'b0;
        case (state)
            IDLE: begin
                // Stray response bytes are drained so they cannot leak into the next transaction.
                clr_rdy = rx_rdy;
                if (send_cmd) begin
                    sh_nxt       = load_word;
                    cnt_nxt      = '0;
                    tmo_nxt      = '0;
                    timeout_nxt  = 1'b0;
                    resp_rdy_nxt = 1'b0;
`ifdef UART_CMD_CHKSUM_EN
                    rsum_nxt     = '0;
                    resp_err_nxt = 1'b0;
`endif
                    state_nxt    = LOAD;
                end
            end
            LOAD: begin
                trmt      = 1'b1;
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    sh_nxt  = sh << 8;
                    cnt_nxt = cnt + 4'd1;
                    if (cnt == CMD_LAST) begin
                        cmd_sent_nxt = 1'b1;
                        cnt_nxt      = '0;
                        tmo_nxt      = '0;
                        state_nxt    = (RESP_TOT > 0) ? RECV : IDLE;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            RECV: begin
                if (rx_rdy) begin
                    clr_rdy = 1'b1;
                    tmo_nxt = '0;
                    cnt_nxt = cnt + 4'd1;
                    if (cnt < RESP_STORE) resp_nxt = (resp << 8) | RESP_W'(rx_data);
`ifdef UART_CMD_CHKSUM_EN
                    rsum_nxt = rsum + rx_data;
`endif
                    if (cnt == RESP_LAST) begin
                        // Assigned after the clear above so a same-cycle set wins.
                        resp_rdy_nxt = 1'b1;
                        state_nxt    = IDLE;
`ifdef UART_CMD_CHKSUM_EN
                        resp_err_nxt = (rsum_nxt != 8'h00);
`endif
                    end
                end else if (tmo == TMO_MAX) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        rst_n_r <= ~rst;
        if (rst) begin
            state    <= IDLE;
            sh       <= '0;
            cnt      <= '0;
            tmo      <= '0;
            resp     <= '0;
            resp_rdy <= 1'b0;
            timeout  <= 1'b0;
            cmd_sent <= 1'b0;
            busy     <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
            rsum     <= '0;
            resp_err <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            sh       <= sh_nxt;
            cnt      <= cnt_nxt;
            tmo      <= tmo_nxt;
            resp     <= resp_nxt;
            resp_rdy <= resp_rdy_nxt;
            timeout  <= timeout_nxt;
            cmd_sent <= cmd_sent_nxt;
            busy     <= (state_nxt != IDLE);
`ifdef UART_CMD_CHKSUM_EN
            rsum     <= rsum_nxt;
            resp_err <= resp_err_nxt;
`endif
        end
    end
endmodule

// File: doc/uart_cmd_resp_mstr.md
Name: uart_cmd_resp_mstr

Overview:
- Parametrised UART command master for the DSO host link. Generalises the fixed 3-byte sender to N command bytes and adds an M-byte response collector with a timeout.
- Serialises a CMD_BYTES-wide command MSB-byte-first through the existing uart_tx, then gathers RESP_BYTES bytes from the existing uart_rx into a response word.
- Sits between the command/test-harness logic and the UART pins.

Parameters:
- CMD_BYTES, 3, number of command bytes sent per transaction (1..8).
- RESP_BYTES, 1, number of response bytes collected per transaction (0..8); 0 means no response phase.
- TIMEOUT_CYC, 2000000, clk cycles allowed between response bytes before abort; counter width is clog2(TIMEOUT_CYC+1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- RX  input  1  UART receive line
- TX  output  1  UART transmit line
- cmd  input  8*CMD_BYTES  command word; byte CMD_BYTES-1 is sent first
- send_cmd  input  1  start request; sampled only in IDLE
- busy  output  1  high from start acceptance until return to IDLE
- cmd_sent  output  1  one-cycle pulse when the last command byte's tx_done is seen
- resp  output  8*RESP_BYTES (min 8)  collected response; first received byte lands in the MS byte
- resp_rdy  output  1  sticky; set when all response bytes are received
- clr_resp_rdy  input  1  clears resp_rdy
- timeout  output  1  sticky; set on response timeout; cleared by the next accepted send_cmd

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. Child uart_tx/uart_rx rst_n is driven by a registered ~rst.
- Reset values: state IDLE; TX idle high (from uart_tx); busy, cmd_sent, resp_rdy and timeout all 0; resp all zeros; byte and timeout counters 0.
- Command capture: cmd is latched into a shift register on acceptance, so later changes to cmd do not affect a transaction in flight.
- States:
  - IDLE: on send_cmd, latch cmd, clear timeout, clear the byte counter, go to LOAD. Never sample send_cmd outside IDLE; such pulses are ignored.
  - LOAD: drive the MS byte of the shift register onto tx_data and pulse trmt for exactly one cycle. Go to WAIT_TX.
  - WAIT_TX: on tx_done, shift the register left by 8 and increment the counter.
    - If the counter reaches CMD_BYTES: pulse cmd_sent, clear the counter, then go to RX if RESP_BYTES>0, else IDLE.
    - Otherwise go back to LOAD.
    - Byte-to-byte gap is at most 2 clk beyond uart_tx's frame time.
  - RX: on rx rdy, shift rx_data into resp from the LS end, pulse clr_rdy to uart_rx, increment the counter and reload the timeout counter.
    - On the RESP_BYTES-th byte: set resp_rdy and go to IDLE.
    - If the timeout counter reaches TIMEOUT_CYC: set timeout and go to IDLE. resp_rdy stays 0 and resp holds the partial data.
- resp_rdy: clr_resp_rdy clears it. If the set and the clear happen in the same cycle, set wins. resp_rdy is also cleared when a new send_cmd is accepted.
- Stray input: response bytes arriving while in IDLE are drained (clr_rdy pulsed) and discarded; resp is unchanged.
- busy: equals (state != IDLE), registered.
- Mid-operation reset: rst asserted in any state returns everything to reset values on the next clk edge. A partially sent frame on TX is truncated and the line returns high.

Optional Feature:
- Macro: UART_CMD_CHKSUM_EN.
- When defined:
  - One extra byte is appended after the command: the 8-bit two's-complement of the sum of all command bytes.
  - One extra response byte is expected. Its sum with all response bytes mod 256 must be 0x00; otherwise resp_err (an extra 1-bit output, sticky, cleared on the next accepted send_cmd) is set alongside resp_rdy.
  - The checksum byte is not stored in resp.
- When undefined: no checksum is sent or checked, and no resp_err port exists.

Test Plan:
- CMD_BYTES=3, RESP_BYTES=1: cmd=0xA5_3C_0F, send_cmd pulse -> TX frames 0xA5, 0x3C, 0x0F in order; one cmd_sent pulse; busy high throughout.
- Loopback TX->RX responder returns 0x5A after the command -> resp=0x5A, resp_rdy=1 until clr_resp_rdy, then 0.
- RESP_BYTES=2 with a responder sending 0x12 then 0x34 -> resp=0x1234; resp_rdy set only after the second byte.
- Responder silent, TIMEOUT_CYC=1000 -> timeout=1 within 1001 clk after cmd_sent, state returns to IDLE, resp_rdy=0; next send_cmd clears timeout.
- rst held for 1 clk during the second byte's frame -> TX high, busy=0, all outputs 0 next cycle; a send_cmd pulse while busy is ignored, giving exactly 3 frames.
- UART_CMD_CHKSUM_EN, cmd=0x01_02_03 -> 4th frame is 0xFA; response 0x10 with checksum 0xF0 gives resp_err=0, checksum 0xF1 gives resp_err=1.
